float_conv_scheduler: RTL
=========================

// Module: float_conv_scheduler
// PURPOSE
//  Shares one combinational float_converter (12-bit two's complement -> S/E[2:0]/F[3:0])
//  between NREQ requesters. Uses round-robin arbitration, registers the winning operand,
//  and returns the registered result tagged with the requester index.
//  Sits between the switch/sample sources and the display/output stage of the lab 2 datapath.
// PARAMETERS
//  NREQ   4   number of requesters (2..8)
//  TAG_W  2   requester index width, = clog2(NREQ)
//  CNT_W  16  width of the completed-conversion counter
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  req_valid  in   NREQ        requester i has an operand on req_data[12*i +: 12]
//  req_data   in   12*NREQ     packed 12-bit two's complement operands
//  req_ready  out  NREQ        one-hot grant; operand i is consumed on the edge where valid&ready
//  out_valid  out  1           result registers hold a valid conversion
//  out_ready  in   1           consumer accepts the result on the edge where valid&ready
//  out_s      out  1           sign bit of the result
//  out_e      out  3           exponent of the result
//  out_f      out  4           mantissa of the result
//  out_tag    out  TAG_W       index of the requester that owns the result
//  busy       out  1           high whenever state != IDLE
//  conv_count out  CNT_W       number of results accepted by the consumer; wraps to 0
// BEHAVIOUR
//  Reset (rst=1 at edge)
//   - state=IDLE, rr_ptr=0, out_valid=0, out_s/e/f/tag=0, conv_count=0, operand register=0.
//   - Reset mid-operation drops any captured or held result; no ready pulse is issued that cycle.
//  FSM: IDLE -> CONV -> HOLD -> IDLE
//   IDLE
//    - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ.
//    - req_ready = onehot(grant), combinational, only in IDLE and only when any req_valid.
//    - On that edge: din_q <= req_data[grant], tag_q <= grant, state <= CONV.
//    - No valid request: stay in IDLE, req_ready=0.
//   CONV
//    - float_converter evaluates din_q.
//    - On the edge: out_s/e/f <= converter outputs unmodified, out_tag <= tag_q,
//      out_valid <= 1, rr_ptr <= (tag_q+1) mod NREQ, state <= HOLD.
//   HOLD
//    - out_* stable while out_valid=1 and out_ready=0.
//    - out_ready=1: out_valid <= 0, conv_count <= conv_count+1, state <= IDLE.
//  Timing
//   - Latency: grant edge -> out_valid high after 2 edges.
//   - Minimum 3 cycles per conversion; req_ready=0 in CONV and HOLD.
//  Requester rules
//   - Requester holds req_data stable while req_valid=1.
//   - Dropping req_valid before grant is legal and has no effect.
//   - Requesters that are not granted keep waiting.
//  Fairness: a requester that stays valid is granted within NREQ conversions.
//  Arithmetic is owned by float_converter: sign-magnitude, leading-zero exponent,
//   round on the 5th bit, saturation to E=7,F=15. This block does not alter results.
//  out_ready while out_valid=0 is ignored. conv_count wraps from 2^CNT_W-1 to 0.
// STRUCTURE
//  Package float_conv_pkg
//   - DIN_W=12, EXP_W=3, MAN_W=4.
//   - State encoding IDLE=2'd0, CONV=2'd1, HOLD=2'd2; 2'd3 recovers to IDLE.
//  Sub-module: one float_converter instance (D_in, S, E, F) driven by din_q.
//  Round-robin priority pick lives in this module; no further hierarchy.
// TESTING
//  1. Reset behaviour:
//     rst high 2 cycles with all req_valid=1 -> req_ready=0, out_valid=0, conv_count=0, busy=0.
//  2. Single request:
//     req0 = 12'b000011110000 -> out_valid 2 edges after grant, S=0, E=4, F=15, tag=0.
//     req0 = 12'b000000101110 -> S=0, E=2, F=12 (round up).
//  3. Negative and saturating operands:
//     12'b111111111111 -> S=1, E=0, F=1.
//     12'b100011110000 -> S=1, E=7, F=14.
//     12'b011111000000 -> S=0, E=7, F=15.
//  4. Contention: all four valid continuously after reset -> tags 0,1,2,3,0 in order;
//     each req_ready is a single-cycle pulse.
//  5. Backpressure: out_ready=0 for 10 cycles in HOLD -> out_* stable and no grants;
//     then out_ready=1 -> conv_count+1 and next grant one cycle later.
//  6. Mid-operation reset: rst pulse in CONV or HOLD -> next cycle IDLE with out_valid=0,
//     then arbitration restarts at requester 0.

Source files
------------

// File: rtl/float_conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : float_conv_pkg
//  Description : Shared widths and FSM state encoding for the float
//                conversion scheduler and its converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package float_conv_pkg;

    localparam int DIN_W = 12;  // two's complement operand width
    localparam int EXP_W = 3;   // result exponent width
    localparam int MAN_W = 4;   // result mantissa width

    // Encoding 2'd3 is unused and steers back to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage : float_conv_pkg
`default_nettype wire

// File: rtl/float_converter.sv
`default_nettype none
// ============================================================================
//  Module      : float_converter
//  Description : Combinational 12-bit two's complement to S/E/F conversion.
//                Value represented is F * 2^E with sign S. The magnitude is
//                normalised on its leading one, the bit below the 4-bit
//                mantissa rounds up, and overflow saturates to E=7, F=15.
//  Revision    : 1.0 - initial release
//  Ports       : D_in  in  [11:0]  two's complement operand
//                S     out         sign
//                E     out [2:0]   exponent
//                F     out [3:0]   mantissa
// ============================================================================
module float_converter
    import float_conv_pkg::*;
(
    input  logic [DIN_W-1:0] D_in,
    output logic             S,
    output logic [EXP_W-1:0] E,
    output logic [MAN_W-1:0] F
);

    logic [DIN_W-1:0] w_mag;
    logic [DIN_W-1:0] w_norm;
    logic [3:0]       w_pos;
    logic [EXP_W:0]   w_exp;   // one extra bit to detect exponent overflow
    logic [MAN_W:0]   w_man;   // one extra bit to detect rounding carry-out

    always_comb begin
        S      = D_in[DIN_W-1];
        // -2048 negates to itself; read as unsigned it is the magnitude 2048.
        w_mag  = S ? (~D_in + 1'b1) : D_in;
        w_norm = '0;
        w_pos  = '0;
        for (int i = 0; i < DIN_W; i++) begin
            if (w_mag[i]) begin
                w_pos = 4'(i);
            end
        end

        if (w_pos <= 4'd3) begin
            // Small magnitudes fit the mantissa exactly.
            w_exp = '0;
            w_man = {1'b0, w_mag[MAN_W-1:0]};
        end else begin
            w_norm = w_mag << (4'(DIN_W - 1) - w_pos);
            w_exp  = w_pos - 4'd3;
            w_man  = {1'b0, w_norm[DIN_W-1 -: MAN_W]} + {4'b0000, w_norm[DIN_W-1-MAN_W]};
            if (w_man[MAN_W]) begin
                // 1111 rounded up becomes 1000 with the exponent bumped.
                w_man = 5'b01000;
                w_exp = w_exp + 4'd1;
            end
        end

        if (w_exp > 4'd7) begin
            E = 3'd7;
            F = 4'd15;
        end else begin
            E = w_exp[EXP_W-1:0];
            F = w_man[MAN_W-1:0];
        end
    end

endmodule : float_converter
`default_nettype wire

// File: rtl/float_conv_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : float_conv_scheduler
//  Description : Round-robin sharing of one float_converter between NREQ
//                requesters. IDLE grants and captures an operand, CONV
//                registers the converted result, HOLD presents it until the
//                consumer accepts it.
//  Revision    : 1.0 - initial release
//  Ports       : clk, rst                 clock, synchronous active-high reset
//                req_valid/req_data       requester operands (12 bits each)
//                req_ready                one-hot grant, IDLE only
//                out_valid/out_ready      result handshake
//                out_s/out_e/out_f        converted result
//                out_tag                  owning requester index
//                busy                     state != IDLE
//                conv_count               accepted results, wrapping
// ============================================================================
module float_conv_scheduler
    import float_conv_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TAG_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [DIN_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_s,
    output logic [EXP_W-1:0]      out_e,
    output logic [MAN_W-1:0]      out_f,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  busy,
    output logic [CNT_W-1:0]      conv_count
);

    state_t           state_q;
    logic [TAG_W-1:0] rr_ptr_q;
    logic [TAG_W-1:0] tag_q;
    logic [DIN_W-1:0] din_q;
    logic             out_valid_q;
    logic             out_s_q;
    logic [EXP_W-1:0] out_e_q;
    logic [MAN_W-1:0] out_f_q;
    logic [TAG_W-1:0] out_tag_q;
    logic [CNT_W-1:0] conv_count_q;

    logic             w_any_d;
    logic [TAG_W-1:0] w_grant_d;
    logic [DIN_W-1:0] w_din_d;
    logic [TAG_W-1:0] w_rr_ptr_d;
    logic             w_conv_s;
    logic [EXP_W-1:0] w_conv_e;
    logic [MAN_W-1:0] w_conv_f;

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        w_any_d   = 1'b0;
        w_grant_d = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                w_any_d   = 1'b1;
                w_grant_d = TAG_W'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    assign w_din_d    = req_data[int'(w_grant_d)*DIN_W +: DIN_W];
    assign w_rr_ptr_d = (tag_q == TAG_W'(NREQ - 1)) ? '0 : tag_q + 1'b1;

    // Grant is suppressed during reset so no operand is consumed on that edge.
    always_comb begin
        req_ready = '0;
        if ((state_q == ST_IDLE) && w_any_d && !rst) begin
            req_ready[w_grant_d] = 1'b1;
        end
    end

    float_converter u_conv (
        .D_in (din_q),
        .S    (w_conv_s),
        .E    (w_conv_e),
        .F    (w_conv_f)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            tag_q        <= '0;
            din_q        <= '0;
            out_valid_q  <= 1'b0;
            out_s_q      <= 1'b0;
            out_e_q      <= '0;
            out_f_q      <= '0;
            out_tag_q    <= '0;
            conv_count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_any_d) begin
                        din_q   <= w_din_d;
                        tag_q   <= w_grant_d;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    out_s_q     <= w_conv_s;
                    out_e_q     <= w_conv_e;
                    out_f_q     <= w_conv_f;
                    out_tag_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    rr_ptr_q    <= w_rr_ptr_d;
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q  <= 1'b0;
                        conv_count_q <= conv_count_q + 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_s      = out_s_q;
    assign out_e      = out_e_q;
    assign out_f      = out_f_q;
    assign out_tag    = out_tag_q;
    assign busy       = (state_q != ST_IDLE);
    assign conv_count = conv_count_q;

endmodule : float_conv_scheduler
`default_nettype wire
